popcount_pipe: RTL

Pipelined, parametrised dual-board population counter with valid/ready flow control. Accepts a pair of WIDTH-bit bitboards (player, opponent) per cycle, returns both disc counts and a tag three cycles later, and stalls cleanly under output backpressure. Sits between the move generator and the evaluation/score stage of the Othello solver, replacing the single combinational 64-bit counter on timing-critical paths.

---
 rtl/popcount_pipe.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/popcount_pipe.sv
// popcount_pipe: three-stage pipelined dual-bitboard population counter with
// valid/ready flow control. Each cycle it takes a player and an opponent
// bitboard and, three register stages later, presents both disc counts and a
// pass-through tag.
// Optional feature: define POPCOUNT_DIFF_EN to add the signed
// out_diff = cnt_p - cnt_o output (CW+1 bits, computed in the last stage).
module popcount_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_o,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_cnt_p,
  output logic [CW-1:0]    out_cnt_o,
`ifdef POPCOUNT_DIFF_EN
  output logic [CW:0]      out_diff,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int NL = WIDTH / 8;     // byte lanes
  localparam int NG = (NL + 3) / 4;  // groups of up to four lanes

  // Bits set in one byte (0..8).
  function automatic logic [3:0] byte_pop(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(b[i]);
    return c;
  endfunction

  // Per-byte counts for a whole board, 4 bits per lane.
  function automatic logic [NL*4-1:0] lane_counts(input logic [WIDTH-1:0] bb);
    logic [NL*4-1:0] l;
    l = '0;
    for (int k = 0; k < NL; k++) l[k*4 +: 4] = byte_pop(bb[k*8 +: 8]);
    return l;
  endfunction

  // Sum lanes in groups of four (max 32, 6 bits); the last group may be short.
  function automatic logic [NG*6-1:0] group_sums(input logic [NL*4-1:0] l);
    logic [NG*6-1:0] g;
    g = '0;
    for (int k = 0; k < NL; k++)
      g[(k/4)*6 +: 6] = g[(k/4)*6 +: 6] + 6'(l[k*4 +: 4]);
    return g;
  endfunction

  // Final board count; the total never exceeds WIDTH so CW bits always hold it.
  function automatic logic [CW-1:0] final_sum(input logic [NG*6-1:0] g);
    logic [CW-1:0] s;
    s = '0;
    for (int j = 0; j < NG; j++) s = s + CW'(g[j*6 +: 6]);
    return s;
  endfunction

`ifdef POPCOUNT_DIFF_EN
  // Two's complement difference, range -WIDTH..+WIDTH.
  function automatic logic signed [CW:0] count_diff(input logic [CW-1:0] a,
                                                    input logic [CW-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction
`endif

  logic adv1, adv2, adv3;
  logic vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;

  logic [NL*4-1:0]  lane_p_p1_q, lane_p_p1_d, lane_o_p1_q, lane_o_p1_d;
  logic [TAG_W-1:0] tag_p1_q, tag_p1_d;
  logic [NG*6-1:0]  grp_p_p2_q, grp_p_p2_d, grp_o_p2_q, grp_o_p2_d;
  logic [TAG_W-1:0] tag_p2_q, tag_p2_d;
  logic [CW-1:0]    cnt_p_p3_q, cnt_p_p3_d, cnt_o_p3_q, cnt_o_p3_d;
  logic [TAG_W-1:0] tag_p3_q, tag_p3_d;
`ifdef POPCOUNT_DIFF_EN
  logic signed [CW:0] diff_p3_q, diff_p3_d;
`endif

  // Advance chain from the output back to the input, plus next-state valids.
  always_comb begin
    adv3     = !vld_p3_q || out_ready;
    adv2     = !vld_p2_q || adv3;
    adv1     = !vld_p1_q || adv2;
    vld_p1_d = adv1 ? in_valid : vld_p1_q;
    vld_p2_d = adv2 ? vld_p1_q : vld_p2_q;
    vld_p3_d = adv3 ? vld_p2_q : vld_p3_q;
  end

  assign in_ready = adv1;

  // ---- stage 1: per-byte counts, loaded only on an accepted input ----
  always_comb begin
    lane_p_p1_d = lane_p_p1_q;
    lane_o_p1_d = lane_o_p1_q;
    tag_p1_d    = tag_p1_q;
    if (adv1 && in_valid) begin
      lane_p_p1_d = lane_counts(in_p);
      lane_o_p1_d = lane_counts(in_o);
      tag_p1_d    = in_tag;
    end
  end

  // ---- stage 2: group partial sums, loaded only when stage 1 hands over ----
  always_comb begin
    grp_p_p2_d = grp_p_p2_q;
    grp_o_p2_d = grp_o_p2_q;
    tag_p2_d   = tag_p1_q;
    if (!(adv2 && vld_p1_q)) tag_p2_d = tag_p2_q;
    if (adv2 && vld_p1_q) begin
      grp_p_p2_d = group_sums(lane_p_p1_q);
      grp_o_p2_d = group_sums(lane_o_p1_q);
    end
  end

  // ---- stage 3: final sums (and difference); drives the outputs ----
  always_comb begin
    cnt_p_p3_d = cnt_p_p3_q;
    cnt_o_p3_d = cnt_o_p3_q;
    tag_p3_d   = tag_p3_q;
`ifdef POPCOUNT_DIFF_EN
    diff_p3_d  = diff_p3_q;
`endif
    if (adv3 && vld_p2_q) begin
      cnt_p_p3_d = final_sum(grp_p_p2_q);
      cnt_o_p3_d = final_sum(grp_o_p2_q);
      tag_p3_d   = tag_p2_q;
`ifdef POPCOUNT_DIFF_EN
      diff_p3_d  = count_diff(final_sum(grp_p_p2_q), final_sum(grp_o_p2_q));
`endif
    end
  end

  // Stage valids: cleared by reset so in-flight entries are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  // Internal stage data: qualified by the valids, so no reset needed.
  always_ff @(posedge clk) begin
    lane_p_p1_q <= lane_p_p1_d;
    lane_o_p1_q <= lane_o_p1_d;
    tag_p1_q    <= tag_p1_d;
    grp_p_p2_q  <= grp_p_p2_d;
    grp_o_p2_q  <= grp_o_p2_d;
    tag_p2_q    <= tag_p2_d;
  end

  // Output stage data: reset so the visible outputs read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p_p3_q <= '0;
      cnt_o_p3_q <= '0;
      tag_p3_q   <= '0;
`ifdef POPCOUNT_DIFF_EN
      diff_p3_q  <= '0;
`endif
    end else begin
      cnt_p_p3_q <= cnt_p_p3_d;
      cnt_o_p3_q <= cnt_o_p3_d;
      tag_p3_q   <= tag_p3_d;
`ifdef POPCOUNT_DIFF_EN
      diff_p3_q  <= diff_p3_d;
`endif
    end
  end

  assign out_valid = vld_p3_q;
  assign out_cnt_p = cnt_p_p3_q;
  assign out_cnt_o = cnt_o_p3_q;
  assign out_tag   = tag_p3_q;
`ifdef POPCOUNT_DIFF_EN
  assign out_diff  = diff_p3_q;
`endif

endmodule
